// File: rtl/uart_prog_loader.sv
// Purpose : downloads a framed program image (SYNC, LEN_HI, LEN_LO, N x 32-bit words MSB first, CSUM)
//           from a UART receiver into instruction memory, holding the CPU in halt while loading.
// Latency : rx_read the cycle after a byte is accepted; mem_we the cycle after the 4th byte of a word.
// Backpressure: bytes are only acknowledged when the FSM can take them (never in DONE/ERROR), so the
//           receiver simply holds rx_new until rx_read arrives.
// Ports   : clk/rst (sync, active-high); rx_data/rx_new/rx_read receiver handshake; mem_we/mem_addr/
//           mem_wdata memory write port; cpu_halt/cpu_rst_req CPU control; busy/done/err/err_code status.
module uart_prog_loader #(
  parameter int          ADDR_W      = 10,
  parameter int          BASE_ADDR   = 0,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_new,
  output logic              rx_read,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_halt,
  output logic              cpu_rst_req,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  // Word index needs one extra bit: a full image holds exactly 2^ADDR_W words.
  localparam int                 IDX_W     = ADDR_W + 1;
  localparam int                 TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [16:0]        MAX_WORDS = 17'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0]  BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] EC_TIMEOUT  = 2'b01;
  localparam logic [1:0] EC_OVERFLOW = 2'b10;
  localparam logic [1:0] EC_CSUM     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t              state_q;
  logic                rx_read_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                cpu_halt_q;
  logic                cpu_rst_req_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [1:0]          err_code_q;
  logic [1:0]          code_q;      // error cause carried into the ERROR state
  logic [15:0]         len_q;
  logic [7:0]          csum_q;
  logic [IDX_W-1:0]    idx_q;
  logic [1:0]          bcnt_q;      // bytes already collected of the current word
  logic [23:0]         buf_q;       // first three bytes; the 4th arrives with the write
  logic [TO_W-1:0]     to_q;

  logic                in_frame_d;
  logic                accept_d;
  logic                timeout_d;
  logic [15:0]         len_d;
  logic [7:0]          csum_d;
  logic [31:0]         word_d;
  logic                last_word_d;

  always_comb begin
    in_frame_d  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                  (state_q == S_DATA)   || (state_q == S_CHECK);
    // The rx_read cycle still sees rx_new high; masking with rx_read_q stops a double accept.
    accept_d    = rx_new && !rx_read_q && (in_frame_d || (state_q == S_IDLE));
    timeout_d   = in_frame_d && !accept_d && (to_q == TO_LAST);
    len_d       = {len_q[15:8], rx_data};
    csum_d      = csum_q + rx_data;
    word_d      = {buf_q, rx_data};
    last_word_d = ((17'(idx_q) + 17'd1) == {1'b0, len_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rx_read_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_halt_q    <= 1'b0;
      cpu_rst_req_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'b00;
      code_q        <= 2'b00;
      len_q         <= '0;
      csum_q        <= '0;
      idx_q         <= '0;
      bcnt_q        <= '0;
      buf_q         <= '0;
      to_q          <= '0;
    end else begin
      rx_read_q     <= accept_d;
      mem_we_q      <= 1'b0;
      cpu_rst_req_q <= 1'b0;

      if (!in_frame_d || accept_d) begin
        to_q <= '0;
      end else begin
        to_q <= to_q + TO_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (accept_d && (rx_data == SYNC_BYTE)) begin
            state_q    <= S_LEN_HI;
            cpu_halt_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            code_q     <= 2'b00;
            idx_q      <= '0;
            csum_q     <= '0;
            bcnt_q     <= '0;
            buf_q      <= '0;
          end
        end

        S_LEN_HI: begin
          if (accept_d) begin
            len_q[15:8] <= rx_data;
            csum_q      <= csum_d;
            state_q     <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (accept_d) begin
            len_q  <= len_d;
            csum_q <= csum_d;
            if ({1'b0, len_d} > MAX_WORDS) begin
              code_q  <= EC_OVERFLOW;
              state_q <= S_ERROR;
            end else if (len_d == 16'd0) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept_d) begin
            csum_q <= csum_d;
            bcnt_q <= bcnt_q + 2'd1;
            buf_q  <= word_d[23:0];
            if (bcnt_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= BASE + idx_q[ADDR_W-1:0];  // wraps modulo 2^ADDR_W
              mem_wdata_q <= word_d;
              idx_q       <= idx_q + IDX_W'(1);
              if (last_word_d) begin
                state_q <= S_CHECK;
              end
            end
          end
        end

        S_CHECK: begin
          if (accept_d) begin
            if (rx_data == csum_q) begin
              state_q <= S_DONE;
            end else begin
              code_q  <= EC_CSUM;
              state_q <= S_ERROR;
            end
          end
        end

        S_DONE: begin
          done_q        <= 1'b1;
          cpu_rst_req_q <= 1'b1;
          cpu_halt_q    <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end

        S_ERROR: begin
          // cpu_halt deliberately stays set: a failed image must not run.
          err_q      <= 1'b1;
          err_code_q <= code_q;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Timeout only fires in a cycle with no accepted byte, so it never races the cases above.
      if (timeout_d) begin
        code_q  <= EC_TIMEOUT;
        state_q <= S_ERROR;
      end
    end
  end

  assign rx_read     = rx_read_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_halt    = cpu_halt_q;
  assign cpu_rst_req = cpu_rst_req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Sequences the UART receiver to download a program image into instruction memory. It consumes bytes through the receiver's new_data/read handshake, parses a framed image (sync, length, 32-bit words, checksum), writes words to memory, and holds the CPU in halt for the whole download. Sits between the UART receive path, the instruction memory write port and the CPU halt/reset controls.

Parameters:
ADDR_W, 10, width of the memory word address; the image may hold at most 2^ADDR_W words.
BASE_ADDR, 0, word address of the first written word.
SYNC_BYTE, 8'hA5, start-of-frame marker.
TIMEOUT_CYC, 2000000, maximum idle clock cycles between accepted bytes inside a frame (about 40 ms at 50 MHz).

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
rx_data  in  8  received byte from the UART receiver.
rx_new  in  1  receiver new_data flag; stays high until cleared by rx_read.
rx_read  out  1  one-cycle acknowledge to the receiver, registered.
mem_we  out  1  one-cycle instruction memory write strobe.
mem_addr  out  ADDR_W  word write address.
mem_wdata  out  32  write data.
cpu_halt  out  1  holds the CPU while a load is in progress or after a failed load.
cpu_rst_req  out  1  one-cycle pulse after a successful load.
busy  out  1  high in every state except IDLE.
done  out  1  sticky; last load succeeded.
err  out  1  sticky; last load failed.
err_code  out  2  00 none, 01 timeout, 10 length overflow, 11 checksum mismatch.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters, checksum and word buffer cleared. Reset asserted mid-load aborts the load immediately. No further mem_we is issued, and cpu_halt drops to 0 on the next cycle.
- Byte accept: a byte is accepted in a cycle where rx_new=1 and rx_read=0. The byte is latched at that edge, and rx_read=1 for exactly the following cycle. rx_new remains high during the rx_read cycle, and that cycle must never be treated as a second byte.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then N = {LEN_HI,LEN_LO} words of 4 bytes each (MSB first), then CSUM.
- CSUM is the 8-bit sum, mod 256, of LEN_HI, LEN_LO and all data bytes.
- States:
  - IDLE: every accepted byte gets rx_read. A byte other than SYNC_BYTE is discarded. SYNC_BYTE goes to LEN_HI and sets cpu_halt=1 and busy=1, and clears done, err and err_code. Word index and checksum are cleared.
  - LEN_HI: on accept, store the byte, add it to the checksum, go to LEN_LO.
  - LEN_LO: on accept, store the byte and add it to the checksum.
    - If N > 2^ADDR_W: go to ERROR with code 10.
    - Else if N = 0: go to CHECK.
    - Else: go to DATA.
  - DATA: shift each accepted byte into the 32-bit buffer and add it to the checksum. After the 4th byte, the next cycle issues mem_we=1 for one cycle, with mem_addr = BASE_ADDR + word_index and mem_wdata = the assembled word; word_index then increments. After word N is written, go to CHECK.
  - CHECK: on accept, compare the byte with the checksum. A match goes to DONE; a mismatch goes to ERROR with code 11.
  - DONE: one cycle. Set done=1, pulse cpu_rst_req=1, clear cpu_halt, return to IDLE.
  - ERROR: one cycle. Set err=1 and latch err_code, keep cpu_halt=1, return to IDLE. cpu_halt is cleared only by a later successful load or by rst.
- Timeout: the counter is cleared on every accepted byte and counts in LEN_HI, LEN_LO, DATA and CHECK. When it reaches TIMEOUT_CYC-1, go to ERROR with code 01. It does not run in IDLE.
- Address arithmetic: BASE_ADDR + word_index is truncated to ADDR_W bits; wrap-around is legal if BASE_ADDR is nonzero.
- A SYNC_BYTE value received inside a frame is treated as data, never as a restart.
- done and err are mutually exclusive and hold until the next SYNC_BYTE is accepted in IDLE.

Test Plan:
- Reset: assert rst for 2 cycles during a DATA phase -> every output is 0 the cycle after reset, and no mem_we follows.
- Good load: send A5 00 02 00 00 00 01 DE AD BE EF 3B -> writes (addr 0, 0x00000001) and (addr 1, 0xDEADBEEF); done=1; one cpu_rst_req pulse; cpu_halt goes 1 then 0; each rx_read is exactly one cycle per byte.
- Bad checksum: send the same frame with CSUM 3C -> both writes occur; err=1, err_code=11, cpu_halt stays 1, done=0, no cpu_rst_req.
- Noise and empty image: send 00 FF 13, then A5 00 00 00 -> the three noise bytes get rx_read and are discarded; no mem_we; done=1.
- Timeout: send A5 00 01 12, then no more bytes for TIMEOUT_CYC cycles (set to 1000 in the bench) -> err=1, err_code=01, state back in IDLE; a following good frame A5 00 01 12 34 56 78 15 succeeds and clears err.
- Length overflow: with ADDR_W=4, send A5 00 11 -> err_code=10 immediately after LEN_LO is accepted; no mem_we.
